// File: rtl/muldiv_pkg.sv
// Shared encodings for the mul/div issue controller: request ops, unit ops and FSM states.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MULT = 3'd0,
        OP_DIV  = 3'd1,
        OP_MTHI = 3'd2,
        OP_MTLO = 3'd3,
        OP_MFHI = 3'd4,
        OP_MFLO = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } req_op_e;

    typedef enum logic [1:0] {
        MD_OP_IDLE = 2'd0,
        MD_OP_MUL  = 2'd1,
        MD_OP_DIV  = 2'd2
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Request/response bundle from the execute stage and launch/result bundle to the mul/div unit.
interface muldiv_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_sign;
    logic [31:0] req_src0;
    logic [31:0] req_src1;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_op, req_sign, req_src0, req_src1,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_op, req_sign, req_src0, req_src1,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

interface muldiv_md_if;
    logic        md_in_valid;
    logic        md_in_ready;
    logic [1:0]  md_op;
    logic        md_sign;
    logic [31:0] md_src0;
    logic [31:0] md_src1;
    logic        md_out_valid;
    logic        md_out_ready;
    logic [31:0] md_res0;
    logic [31:0] md_res1;

    modport master (
        output md_in_valid, md_op, md_sign, md_src0, md_src1, md_out_ready,
        input  md_in_ready, md_out_valid, md_res0, md_res1
    );
    modport slave (
        input  md_in_valid, md_op, md_sign, md_src0, md_src1, md_out_ready,
        output md_in_ready, md_out_valid, md_res0, md_res1
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// HI/LO owner and issue FSM in front of the mul/div unit.
// Optional MULDIV_ISSUE_BYPASS_EN: MFHI/MFLO accepted in WAIT as the result arrives.
module muldiv_issue_ctrl
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    muldiv_req_if.slave req,
    muldiv_md_if.master md,
    output logic        busy
);

    state_e      state_q, state_d;
    md_op_e      md_op_q, md_op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        sign_q, sign_d;
    logic [31:0] src0_q, src0_d;
    logic [31:0] src1_q, src1_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        req_ready;
    logic        accept;
    req_op_e     op;

    assign op = req_op_e'(req.req_op);

    always_comb begin
        state_d     = state_q;
        md_op_d     = md_op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        sign_d      = sign_q;
        src0_d      = src0_q;
        src1_d      = src1_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef MULDIV_ISSUE_BYPASS_EN
        req_ready   = (state_q == ST_IDLE) ||
                      ((state_q == ST_WAIT) && md.md_out_valid &&
                       ((op == OP_MFHI) || (op == OP_MFLO)));
`else
        req_ready   = (state_q == ST_IDLE);
`endif
        accept      = req.req_valid && req_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_DIV: begin
                            src0_d  = req.req_src0;
                            src1_d  = req.req_src1;
                            sign_d  = req.req_sign;
                            md_op_d = (op == OP_MULT) ? MD_OP_MUL : MD_OP_DIV;
                            state_d = ST_ISSUE;
                        end
                        OP_MTHI: hi_d = req.req_src0;
                        OP_MTLO: lo_d = req.req_src0;
                        OP_MFHI: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = hi_q;
                        end
                        OP_MFLO: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = lo_q;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (md.md_in_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (md.md_out_valid) begin
                    lo_d    = md.md_res0;
                    hi_d    = md.md_res1;
                    md_op_d = MD_OP_IDLE;
                    state_d = ST_IDLE;
                    // Only reachable with bypass: forward the fresh result, not the stale HI/LO.
                    if (accept) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = (op == OP_MFHI) ? md.md_res1 : md.md_res0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            md_op_q     <= MD_OP_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            md_op_q     <= md_op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Operand registers carry data only; md_op gates their meaning.
    always_ff @(posedge clock) begin
        sign_q <= sign_d;
        src0_q <= src0_d;
        src1_q <= src1_d;
    end

    assign req.req_ready  = req_ready;
    assign req.rsp_valid  = rsp_valid_q;
    assign req.rsp_data   = rsp_data_q;
    assign md.md_in_valid = (state_q == ST_ISSUE);
    assign md.md_out_ready = (state_q == ST_WAIT);
    assign md.md_op       = md_op_q;
    assign md.md_sign     = sign_q;
    assign md.md_src0     = src0_q;
    assign md.md_src1     = src1_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: bench-side mul/div unit model plus HI/LO reference model.
module tb_muldiv_issue_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic busy;

  muldiv_req_if rq();
  muldiv_md_if  mdi();

  muldiv_issue_ctrl dut (
    .clock (clock),
    .reset (reset),
    .req   (rq),
    .md    (mdi),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  int          hold_errs;
  logic [1:0]  h_mop;
  logic        h_sign;
  logic [31:0] h_s0, h_s1;

  typedef struct {
    logic [2:0]  op;
    logic        sign;
    logic [31:0] s0;
    logic [31:0] s1;
    int          in_dly;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vec[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Behaviour of the downstream unit; division by zero returns {dividend, all-ones}.
  function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    longint sa, sb, q, r;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd0) begin
      if (sgn) return 64'(sa * sb);
      return ua * ub;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic hold_sample(input bit chk_ready);
    if (mdi.md_op !== h_mop || mdi.md_sign !== h_sign ||
        mdi.md_src0 !== h_s0 || mdi.md_src1 !== h_s1) hold_errs++;
    if (chk_ready && rq.req_ready !== 1'b0) hold_errs++;
  endtask

  // probe: 0 none, 1 MTLO presented while busy, 2 MFLO at result arrival, 3 reset mid-WAIT
  task automatic run_op(input logic [2:0] op, input logic sign, input logic [31:0] s0,
                        input logic [31:0] s1, input int in_dly, input int lat,
                        input int probe, output logic [31:0] rsp);
    int n;
    logic [63:0] res;
    logic [31:0] mt_val;
    rsp = '0;
    rq.req_valid = 1'b1;
    rq.req_op    = op;
    rq.req_sign  = sign;
    rq.req_src0  = s0;
    rq.req_src1  = s1;
    n = 0;
    #1;
    while (rq.req_ready !== 1'b1 && n < 50) begin
      tick(); #1; n++;
    end
    if (n >= 50) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      rq.req_valid = 1'b0;
      return;
    end
    tick();
    rq.req_valid = 1'b0;
    #1;
    case (op)
      3'd4, 3'd5: begin
        check("rsp_valid", rq.rsp_valid, 1'b1);
        check("rsp_data", rq.rsp_data, (op == 3'd4) ? m_hi : m_lo);
        rsp = rq.rsp_data;
        tick(); #1;
        check("rsp_pulse", rq.rsp_valid, 1'b0);
      end
      3'd2: m_hi = s0;
      3'd3: m_lo = s0;
      3'd6, 3'd7: check("rsv_no_rsp", {rq.rsp_valid, busy}, 2'b00);
      default: begin
        res       = unit_calc(op, sign, s0, s1);
        h_mop     = (op == 3'd0) ? 2'd1 : 2'd2;
        h_sign    = sign;
        h_s0      = s0;
        h_s1      = s1;
        hold_errs = 0;
        check("issue_state", {busy, mdi.md_in_valid, mdi.md_out_ready}, 3'b110);
        for (int i = 0; i < in_dly; i++) begin
          mdi.md_in_ready = 1'b0;
          hold_sample(1'b1);
          tick(); #1;
        end
        mdi.md_in_ready = 1'b1;
        hold_sample(1'b1);
        tick();
        mdi.md_in_ready = 1'b0;
        #1;
        check("wait_state", {busy, mdi.md_in_valid, mdi.md_out_ready}, 3'b101);
        if (probe == 3) begin
          tick();
          reset = 1'b1;
          tick();
          reset = 1'b0;
          #1;
          check("rst_ctrl", {busy, mdi.md_in_valid, mdi.md_out_ready, rq.rsp_valid, rq.req_ready}, 5'b00001);
          check("rst_mdop_data", {mdi.md_op, rq.rsp_data}, 34'd0);
          m_hi = '0;
          m_lo = '0;
          return;
        end
        mt_val = 32'h5A5A_0001;
        if (probe == 1) begin
          rq.req_valid = 1'b1;
          rq.req_op    = 3'd3;
          rq.req_src0  = mt_val;
        end
        for (int i = 0; i < lat; i++) begin
          hold_sample(1'b1);
          tick(); #1;
        end
        mdi.md_out_valid = 1'b1;
        mdi.md_res0      = res[31:0];
        mdi.md_res1      = res[63:32];
        if (probe == 2) begin
          rq.req_valid = 1'b1;
          rq.req_op    = 3'd5;
        end
        #1;
        hold_sample(probe != 2);
        if (probe == 2) begin
`ifdef MULDIV_ISSUE_BYPASS_EN
          check("bypass_ready", rq.req_ready, 1'b1);
`else
          check("bypass_ready", rq.req_ready, 1'b0);
`endif
        end
        tick();
        mdi.md_out_valid = 1'b0;
        m_hi = res[63:32];
        m_lo = res[31:0];
`ifdef MULDIV_ISSUE_BYPASS_EN
        if (probe == 2) rq.req_valid = 1'b0;
`endif
        #1;
        check("done_state", {busy, mdi.md_in_valid, mdi.md_out_ready, mdi.md_op}, 5'b00000);
        check("md_hold", hold_errs, 0);
        if (probe == 1) begin
          check("mtlo_ready_idle", rq.req_ready, 1'b1);
          tick();
          rq.req_valid = 1'b0;
          m_lo = mt_val;
          #1;
        end
        if (probe == 2) begin
`ifndef MULDIV_ISSUE_BYPASS_EN
          check("post_ready", rq.req_ready, 1'b1);
          tick();
          rq.req_valid = 1'b0;
          #1;
`endif
          check("bypass_valid", rq.rsp_valid, 1'b1);
          check("bypass_rsp", rq.rsp_data, m_lo);
          rsp = rq.rsp_data;
          tick(); #1;
        end
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    vec[0] = '{3'd0, 1'b1, 32'hFFFF_FFFE, 32'd3,          0, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vec[1] = '{3'd1, 1'b0, 32'd100,       32'd7,          3, 2, 32'd2,         32'd14};
    vec[2] = '{3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1, 1, 32'hFFFF_FFFE, 32'h0000_0001};
    vec[3] = '{3'd1, 1'b1, 32'hFFFF_FFF9, 32'd2,          0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vec[4] = '{3'd0, 1'b1, 32'h8000_0000, 32'h8000_0000,  2, 1, 32'h4000_0000, 32'h0000_0000};
    vec[5] = '{3'd1, 1'b0, 32'd5,         32'd0,          0, 2, 32'd5,         32'hFFFF_FFFF};
    vec[6] = '{3'd2, 1'b0, 32'h1234_5678, 32'd0,          0, 0, 32'h1234_5678, 32'hFFFF_FFFF};
    vec[7] = '{3'd3, 1'b0, 32'hCAFE_F00D, 32'd0,          0, 0, 32'h1234_5678, 32'hCAFE_F00D};
    vec[8] = '{3'd6, 1'b0, 32'h0000_DEAD, 32'd1,          0, 0, 32'h1234_5678, 32'hCAFE_F00D};
    vec[9] = '{3'd7, 1'b1, 32'h0000_BEEF, 32'd2,          0, 0, 32'h1234_5678, 32'hCAFE_F00D};

    reset = 1'b1;
    rq.req_valid = 1'b0; rq.req_op = 3'd0; rq.req_sign = 1'b0;
    rq.req_src0 = '0; rq.req_src1 = '0;
    mdi.md_in_ready = 1'b0; mdi.md_out_valid = 1'b0;
    mdi.md_res0 = '0; mdi.md_res1 = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset_ctrl", {busy, mdi.md_in_valid, mdi.md_out_ready, rq.rsp_valid, rq.req_ready}, 5'b00001);
    check("reset_mdop_data", {mdi.md_op, rq.rsp_data}, 34'd0);
    run_op(3'd4, 1'b0, 0, 0, 0, 0, 0, r); check("reset_hi", r, 32'd0);
    run_op(3'd5, 1'b0, 0, 0, 0, 0, 0, r); check("reset_lo", r, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vec[i].op, vec[i].sign, vec[i].s0, vec[i].s1, vec[i].in_dly, vec[i].lat, 0, r);
      run_op(3'd4, 1'b0, 0, 0, 0, 0, 0, r);
      check($sformatf("vec%0d_hi", i), r, vec[i].exp_hi);
      run_op(3'd5, 1'b0, 0, 0, 0, 0, 0, r);
      check($sformatf("vec%0d_lo", i), r, vec[i].exp_lo);
    end

    run_op(3'd0, 1'b1, 32'd7, 32'd9, 1, 3, 3, r);
    run_op(3'd4, 1'b0, 0, 0, 0, 0, 0, r); check("midwait_rst_hi", r, 32'd0);
    run_op(3'd5, 1'b0, 0, 0, 0, 0, 0, r); check("midwait_rst_lo", r, 32'd0);

    run_op(3'd2, 1'b0, 32'h1234_5678, 0, 0, 0, 0, r);
    run_op(3'd4, 1'b0, 0, 0, 0, 0, 0, r); check("mt_mf_turnaround", r, 32'h1234_5678);

    run_op(3'd0, 1'b0, 32'd3, 32'd4, 0, 3, 1, r);
    run_op(3'd5, 1'b0, 0, 0, 0, 0, 0, r); check("mtlo_after_busy", r, 32'h5A5A_0001);
    run_op(3'd4, 1'b0, 0, 0, 0, 0, 0, r); check("mul_hi_kept", r, 32'd0);

    run_op(3'd0, 1'b0, 32'h0000_00AA, 32'd1, 1, 2, 2, r);
    check("bypass_value", r, 32'h0000_00AA);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          pr;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5))  : $urandom;
      pr = (op <= 3'd1 && $urandom_range(0, 3) == 0) ? 2 : 0;
      run_op(op, 1'($urandom_range(0, 1)), a, b,
             $urandom_range(0, 3), $urandom_range(0, 4), pr, r);
    end
    run_op(3'd4, 1'b0, 0, 0, 0, 0, 0, r);
    run_op(3'd5, 1'b0, 0, 0, 0, 0, 0, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

- Sits directly upstream of the multiply/divide unit and owns the architectural HI/LO register pair.
- Accepts MIPS-style mul/div/move requests from the execute stage through a valid/ready handshake.
- Launches MULT/DIV operations into the unit and holds its operands and op stable until the result is taken.
- Writes LO/HI from the unit's two result words and stalls HI/LO reads and writes while an operation is in flight.

## Interface
- Parameters: none (widths fixed at 32 bits).
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  3  0 MULT, 1 DIV, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO, 6/7 reserved.
- req_sign  in  1  signed mul/div when 1.
- req_src0  in  32  rs operand; also the data for MTHI/MTLO.
- req_src1  in  32  rt operand.
- rsp_valid  out  1  one-cycle pulse carrying MFHI/MFLO data.
- rsp_data  out  32  HI or LO value.
- busy  out  1  state != IDLE.
- md_in_valid  out  1  launch to the mul/div unit.
- md_in_ready  in  1  unit accepts the launch.
- md_op  out  2  0 idle, 1 mul, 2 div.
- md_sign  out  1  registered req_sign.
- md_src0  out  32  registered operand.
- md_src1  out  32  registered operand.
- md_out_valid  in  1  unit result available.
- md_out_ready  out  1  result taken.
- md_res0  in  32  LO result (product low / quotient).
- md_res1  in  32  HI result (product high / remainder).

## Operation

**States.** IDLE, ISSUE, WAIT.

**IDLE.**
- req_ready=1.
- On acceptance:
  - MULT/DIV: latch src0, src1 and sign; set md_op (1 or 2); go to ISSUE.
  - MTHI/MTLO: write req_src0 to HI or LO next edge.
  - MFHI/MFLO: rsp_valid=1 next cycle with the current HI or LO value.
  - Reserved ops: accepted with no effect and no response.

**ISSUE.**
- md_in_valid=1.
- On md_in_valid & md_in_ready, go to WAIT.

**WAIT.**
- md_out_ready=1.
- On md_out_valid: LO<=md_res0, HI<=md_res1, md_op<=0, go to IDLE.

**Busy rules.**
- In ISSUE and WAIT, req_ready=0 for every op.
- md_op, md_sign, md_src0 and md_src1 are held constant from entry to ISSUE until the WAIT handshake completes. The unit selects its result by op, so this is mandatory.

**Divide by zero.** HI/LO take whatever the unit returns; no trap.

**Reset.**
- state=IDLE, HI=LO=0.
- md_op=0, md_in_valid=0, md_out_ready=0.
- rsp_valid=0, rsp_data=0.
- An in-flight operation is discarded. The unit shares reset, so no stale result can arrive.

## Timing
- Request accepted at edge T → md_in_valid high from cycle T+1. Minimum mul/div occupancy is 2 cycles plus the unit's latency.
- HI/LO are updated at the edge where md_out_valid & md_out_ready are both high. The next request can be accepted in the following cycle.
- MFHI/MFLO accepted in cycle T → rsp_valid and rsp_data valid in cycle T+1 only.
- MTHI/MTLO accepted in cycle T → new value visible to an MF accepted in cycle T+1.
- req_ready depends only on state, never on req_valid.

## Configuration
Macro MULDIV_ISSUE_BYPASS_EN.

**Defined:**
- In WAIT, when md_out_valid=1 and the request is MFHI/MFLO, req_ready=1.
- The request is accepted that cycle and rsp_data next cycle carries md_res1 or md_res0, i.e. the new value.
- Any other op in WAIT still stalls.

**Undefined:** all requests stall until IDLE, which costs one extra cycle.

## Structure
- Package muldiv_pkg holds:
  - the req_op encodings (OP_MULT … OP_MFLO);
  - the md_op encodings (MD_OP_IDLE=0, MD_OP_MUL=1, MD_OP_DIV=2);
  - the state enum.
- Single module with no sub-modules.
- HI/LO, the FSM and the operand registers live inline.

## Test plan
- **Reset:** assert reset mid-WAIT → next cycle state IDLE, HI=LO=0, md_in_valid=0, busy=0.
- **MULT:** MULT signed with src0=0xFFFFFFFE (-2) and src1=3; model returns res1=0xFFFFFFFF, res0=0xFFFFFFFA after 4 cycles. Then MFHI → 0xFFFFFFFF and MFLO → 0xFFFFFFFA. md_op is stable at 1 throughout.
- **DIV:** DIVU 100/7 with md_in_ready held low 3 cycles → md_src0/src1 held constant; then MFLO=14, MFHI=2.
- **MT/MF turnaround:** MTHI 0x12345678, then MFHI back-to-back → rsp_data=0x12345678 one cycle later. MTLO issued while busy → req_ready=0 until IDLE.
- **Bypass:** MFLO presented during WAIT as md_out_valid rises with res0=0xAA.
  - Macro defined: accepted that cycle, rsp_data=0xAA.
  - Macro undefined: accepted one cycle later, rsp_data=0xAA.
- **Reserved op:** reserved op 6 → accepted, no rsp_valid, HI/LO unchanged.
